// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// response error bit positions and a funct3 legality helper.
package load_store_unit_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  localparam int LSU_ERR_ILLEGAL  = 0;
  localparam int LSU_ERR_MISALIGN = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == STORE_SB) || (f3 == STORE_SH) || (f3 == STORE_SW);
    end
    return (f3 == LOAD_LB) || (f3 == LOAD_LH) || (f3 == LOAD_LW) ||
           (f3 == LOAD_LBU) || (f3 == LOAD_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_align_check.sv
// Combinational natural-alignment check for halfword and word accesses.
// Instantiated by load_store_unit only when LSU_MISALIGN_TRAP_EN is defined.
module load_store_unit_align_check (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);

  // size_i is funct3[1:0]: 01 = halfword, 10 = word, byte never misaligns.
  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      2'b01:   misaligned_o = addr_lo_i[0];
      2'b10:   misaligned_o = (addr_lo_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory port: one load/store in flight, IDLE -> ACCESS -> RESP.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (suppress and flag misaligned half/word accesses).
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | latched request drives the memory port for exactly one cycle
// RESP   | response presented and held until rsp_ready
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TAG_W      = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  input  logic [TAG_W-1:0]      req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [1:0]            rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_illegal_read_address,
  output logic [2:0]            mem_size_and_sign,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic                  mem_illegal_write_address
);

  lsu_state_e            state_q;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [TAG_W-1:0]      tag_q;
  logic [31:0]           rdata_q;
  logic [1:0]            error_q;
  logic                  rsp_valid_q;

  logic                  misaligned;
  logic                  funct3_bad;
  logic [1:0]            error_d;
  logic [31:0]           rdata_d;

`ifdef LSU_MISALIGN_TRAP_EN
  load_store_unit_align_check u_align_check (
    .size_i       (funct3_q[1:0]),
    .addr_lo_i    (addr_q[1:0]),
    .misaligned_o (misaligned)
  );
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    funct3_bad                = !funct3_legal(write_q, funct3_q);
    error_d                   = 2'b00;
    error_d[LSU_ERR_ILLEGAL]  = funct3_bad |
                                (write_q ? mem_illegal_write_address : mem_illegal_read_address);
    error_d[LSU_ERR_MISALIGN] = misaligned;
    // Any error, and every store, returns zero data.
    rdata_d = (!write_q && (error_d == 2'b00)) ? mem_read_data : 32'h0;
  end

  // Combinational gate on the decode result so an illegal or trapped store never strobes;
  // state_q resets asynchronously, so the strobe also drops the moment reset_n falls.
  assign mem_write_enable = (state_q == ST_ACCESS) & write_q & ~funct3_bad &
                            ~mem_illegal_write_address & ~misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      tag_q       <= '0;
      rdata_q     <= 32'h0;
      error_q     <= 2'b00;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_address;
            wdata_q  <= req_wdata;
            tag_q    <= req_tag;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q     <= rdata_d;
          error_q     <= error_d;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready         = (state_q == ST_IDLE);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rdata_q;
  assign rsp_tag           = tag_q;
  assign rsp_error         = error_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_size_and_sign = funct3_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural rom@0x0000 / ram@0x1000 memory
// and a response scoreboard.
module tb_load_store_unit;

  localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010, F_LBU = 3'b100, F_LHU = 3'b101;
  localparam logic [2:0] F_SB = 3'b000, F_SW = 3'b010;

  logic        clk;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic [4:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_tag;
  logic [1:0]  rsp_error;
  logic [31:0] mem_read_address, mem_read_data;
  logic        mem_illegal_read_address;
  logic [2:0]  mem_size_and_sign;
  logic [31:0] mem_write_address, mem_write_data;
  logic        mem_write_enable, mem_illegal_write_address;

  load_store_unit #(.TAG_W(5), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .rsp_error(rsp_error),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_illegal_read_address(mem_illegal_read_address), .mem_size_and_sign(mem_size_and_sign),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_illegal_write_address(mem_illegal_write_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int rsp_count = 0;
  int rsp_rise_cyc = 0;
  logic rsp_valid_prev = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  tag;
    logic [1:0]  err;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;

  // Memory model: bytes 0x0000-0x0FFF rom (word k = 0xC0DE0000 | k), 0x1000-0x1FFF ram.
  logic [7:0]  mem [0:8191];
  logic [12:0] ra, wa;
  logic [31:0] rw;
  assign wa = mem_write_address[12:0];
  assign mem_illegal_write_address = (mem_write_address < 32'h1000) || (mem_write_address >= 32'h2000);

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'hC0DE0000 | i;
      mem[4*i] = w[7:0]; mem[4*i+1] = w[15:8]; mem[4*i+2] = w[23:16]; mem[4*i+3] = w[31:24];
    end
    for (int i = 4096; i < 8192; i++) mem[i] = 8'h00;
  end

  always_comb begin
    mem_illegal_read_address = (mem_read_address >= 32'h2000);
    ra = mem_read_address[12:0];
    rw = {mem[ra + 13'd3], mem[ra + 13'd2], mem[ra + 13'd1], mem[ra]};
    case (mem_size_and_sign)
      3'b000:  mem_read_data = {{24{rw[7]}}, rw[7:0]};
      3'b001:  mem_read_data = {{16{rw[15]}}, rw[15:0]};
      3'b100:  mem_read_data = {24'h0, rw[7:0]};
      3'b101:  mem_read_data = {16'h0, rw[15:0]};
      default: mem_read_data = rw;
    endcase
    if (mem_illegal_read_address) mem_read_data = 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    cyc++;
    if (mem_write_enable) begin
      strobe_cnt++;
      if (!mem_illegal_write_address) begin
        case (mem_size_and_sign)
          3'b000: mem[wa] <= mem_write_data[7:0];
          3'b001: begin
            mem[wa] <= mem_write_data[7:0]; mem[wa + 13'd1] <= mem_write_data[15:8];
          end
          3'b010: begin
            mem[wa]         <= mem_write_data[7:0];   mem[wa + 13'd1] <= mem_write_data[15:8];
            mem[wa + 13'd2] <= mem_write_data[23:16]; mem[wa + 13'd3] <= mem_write_data[31:24];
          end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard: compare each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid && !rsp_valid_prev) rsp_rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_rsp tag=%0d rdata=%h", rsp_tag, rsp_rdata);
        end else begin
          sb_e = sb_q.pop_front();
          checks++;
          if (rsp_rdata !== sb_e.rdata) begin
            errors++; $display("FAIL sb_rdata tag=%0d got=%h want=%h", sb_e.tag, rsp_rdata, sb_e.rdata);
          end
          checks++;
          if (rsp_tag !== sb_e.tag) begin
            errors++; $display("FAIL sb_tag got=%0d want=%0d", rsp_tag, sb_e.tag);
          end
          checks++;
          if (rsp_error !== sb_e.err) begin
            errors++; $display("FAIL sb_error tag=%0d got=%b want=%b", sb_e.tag, rsp_error, sb_e.err);
          end
        end
        rsp_count++;
      end
    end
    rsp_valid_prev = rsp_valid;
  end

  // Drive one request, push its expectation, wait for the scoreboard to consume the response.
  // req_c: cycle the accepted request was presented; lat: cycles from then to rsp_valid.
  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] tag, input logic [31:0] exp_rd,
                      input logic [1:0] exp_err, output int req_c, output int lat);
    exp_t e;
    int target, n;
    e.rdata = exp_rd; e.tag = tag; e.err = exp_err;
    sb_q.push_back(e);
    target = rsp_count + 1;
    req_c = 0; lat = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_wdata = wd; req_tag = tag;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout tag=%0d got=%b want=1", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    req_c = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_count < target && n < 50) begin @(negedge clk); #2; n++; end
    if (rsp_count < target) begin
      checks++; errors++;
      $display("FAIL rsp_timeout tag=%0d got=%0d want=%0d", tag, rsp_count, target);
    end
    lat = rsp_rise_cyc - req_c;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_address = 32'h0; req_wdata = 32'h0; req_tag = 5'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (rsp_tag !== 5'h0) begin errors++; $display("FAIL reset_rsp_tag got=%h want=0", rsp_tag); end
    checks++; if (rsp_error !== 2'b00) begin errors++; $display("FAIL reset_rsp_error got=%b want=00", rsp_error); end
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b want=0", mem_write_enable); end
    checks++; if (mem_read_address !== 32'h0) begin errors++; $display("FAIL reset_raddr got=%h want=0", mem_read_address); end
    checks++; if (mem_write_address !== 32'h0) begin errors++; $display("FAIL reset_waddr got=%h want=0", mem_write_address); end
    checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", mem_write_data); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_load_rom();
    int rc, lat;
    send(1'b0, F_LW, 32'h0000_0000, 32'h0, 5'd5, 32'hC0DE0000, 2'b00, rc, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL load_latency got=%0d want=2", lat); end
  endtask

  task automatic test_store_load();
    int rc, lat, s0;
    s0 = strobe_cnt;
    send(1'b1, F_SW, 32'h1000, 32'hDEADBEEF, 5'd1, 32'h0, 2'b00, rc, lat);
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL sw_strobes got=%0d want=1", strobe_cnt - s0); end
    send(1'b0, F_LW, 32'h1000, 32'h0, 5'd2, 32'hDEADBEEF, 2'b00, rc, lat);
    s0 = strobe_cnt;
    send(1'b1, F_SB, 32'h1000, 32'h0000_0080, 5'd3, 32'h0, 2'b00, rc, lat);
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL sb_strobes got=%0d want=1", strobe_cnt - s0); end
    send(1'b0, F_LB,  32'h1000, 32'h0, 5'd4, 32'hFFFFFF80, 2'b00, rc, lat);
    send(1'b0, F_LBU, 32'h1000, 32'h0, 5'd6, 32'h00000080, 2'b00, rc, lat);
    send(1'b0, F_LW,  32'h1000, 32'h0, 5'd10, 32'hDEADBE80, 2'b00, rc, lat);
  endtask

  task automatic test_illegal();
    int rc, lat, s0;
    s0 = strobe_cnt;
    send(1'b1, F_SW, 32'h0000_0010, 32'h12345678, 5'd11, 32'h0, 2'b01, rc, lat);
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL rom_store_strobe got=%0d want=0", strobe_cnt - s0); end
    send(1'b0, F_LW, 32'h0000_8000, 32'h0, 5'd12, 32'h0, 2'b01, rc, lat);
    send(1'b0, 3'b011, 32'h1000, 32'h0, 5'd13, 32'h0, 2'b01, rc, lat);
    s0 = strobe_cnt;
    send(1'b1, 3'b100, 32'h1004, 32'hA5A5A5A5, 5'd14, 32'h0, 2'b01, rc, lat);
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL bad_f3_store_strobe got=%0d want=0", strobe_cnt - s0); end
    send(1'b0, F_LW, 32'hFFFF_FFFC, 32'h0, 5'd15, 32'h0, 2'b01, rc, lat);
    checks++; if (mem_read_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h want=fffffffc", mem_read_address); end
  endtask

  task automatic test_misalign();
    int rc, lat, s0;
    s0 = strobe_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, F_LH, 32'h1001, 32'h0, 5'd16, 32'h0, 2'b10, rc, lat);
    send(1'b1, F_SW, 32'h1002, 32'h11223344, 5'd17, 32'h0, 2'b10, rc, lat);
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL misalign_strobe got=%0d want=0", strobe_cnt - s0); end
    send(1'b0, F_LW, 32'h1004, 32'h0, 5'd18, 32'h0000_0000, 2'b00, rc, lat);
`else
    send(1'b0, F_LH, 32'h1001, 32'h0, 5'd16, 32'hFFFFADBE, 2'b00, rc, lat);
    send(1'b1, F_SW, 32'h1002, 32'h11223344, 5'd17, 32'h0, 2'b00, rc, lat);
    checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL misalign_strobe got=%0d want=1", strobe_cnt - s0); end
    send(1'b0, F_LW, 32'h1004, 32'h0, 5'd18, 32'h0000_1122, 2'b00, rc, lat);
`endif
  endtask

  task automatic test_back_to_back();
    int rc0, rc1, rc2, lat;
    send(1'b0, F_LW,  32'h0008, 32'h0, 5'd19, 32'hC0DE0002, 2'b00, rc0, lat);
    send(1'b0, F_LHU, 32'h0002, 32'h0, 5'd20, 32'h0000C0DE, 2'b00, rc1, lat);
    send(1'b0, F_LH,  32'h0002, 32'h0, 5'd21, 32'hFFFFC0DE, 2'b00, rc2, lat);
    checks++; if (rc1 - rc0 != 3) begin errors++; $display("FAIL b2b_spacing_1 got=%0d want=3", rc1 - rc0); end
    checks++; if (rc2 - rc1 != 3) begin errors++; $display("FAIL b2b_spacing_2 got=%0d want=3", rc2 - rc1); end
  endtask

  task automatic test_hold();
    exp_t e;
    int base, n;
    base = rsp_count;
    e.rdata = 32'hC0DE0001; e.tag = 5'd7; e.err = 2'b00; sb_q.push_back(e);
    e.rdata = 32'h000000C0; e.tag = 5'd8; e.err = 2'b00; sb_q.push_back(e);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F_LW; req_address = 32'h4; req_tag = 5'd7;
    @(negedge clk);
    @(posedge clk); #1;
    req_funct3 = F_LBU; req_address = 32'h3; req_tag = 5'd8;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_valid k=%0d got=%b want=1", k, rsp_valid); end
      checks++; if (rsp_rdata !== 32'hC0DE0001) begin errors++; $display("FAIL hold_rdata k=%0d got=%h want=c0de0001", k, rsp_rdata); end
      checks++; if (rsp_tag !== 5'd7) begin errors++; $display("FAIL hold_tag k=%0d got=%0d want=7", k, rsp_tag); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_req_ready k=%0d got=%b want=0", k, req_ready); end
    end
    checks++; if (rsp_count != base) begin errors++; $display("FAIL hold_consumed got=%0d want=%0d", rsp_count - base, 0); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_count < base + 2 && n < 20) begin @(negedge clk); #2; n++; end
    checks++; if (rsp_count != base + 2) begin errors++; $display("FAIL hold_rsp_count got=%0d want=%0d", rsp_count - base, 2); end
  endtask

  task automatic test_reset_mid_store();
    int s0, c0;
    c0 = rsp_count;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_SW; req_address = 32'h1008;
    req_wdata = 32'hCAFEF00D; req_tag = 5'd9;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL rst_access_wen got=%b want=1", mem_write_enable); end
    s0 = strobe_cnt;
    reset_n = 1'b0;
    #1;
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_wen_drop got=%b want=0", mem_write_enable); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL rst_strobe got=%0d want=0", strobe_cnt - s0); end
    checks++;
    if ({mem[13'h100B], mem[13'h100A], mem[13'h1009], mem[13'h1008]} !== 32'h0) begin
      errors++;
      $display("FAIL rst_mem got=%h want=0", {mem[13'h100B], mem[13'h100A], mem[13'h1009], mem[13'h1008]});
    end
    checks++; if (rsp_count != c0) begin errors++; $display("FAIL rst_rsp_discard got=%0d want=0", rsp_count - c0); end
  endtask

  initial begin
    test_reset();
    test_load_rom();
    test_store_load();
    test_illegal();
    test_misalign();
    test_back_to_back();
    test_hold();
    test_reset_mid_store();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
